// File: rtl/sseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with a valid/ready shadow load.
// Optional macro SSEG_LEADING_ZERO_BLANK_EN blanks digits above the highest nonzero nibble.
module sseg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] value_in,
  input  logic [7:0]  dp_mask_in,
  input  logic        value_valid_in,
  output logic        value_ready_out,
  output logic [6:0]  sseg_out,
  output logic        dp_out,
  output logic [7:0]  an_out
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_dig;
  logic [31:0]      r_disp_val;
  logic [7:0]       r_disp_dp;
  logic [31:0]      r_shadow_val;
  logic [7:0]       r_shadow_dp;
  logic             r_pend;
  logic [6:0]       r_sseg;
  logic             r_dp;
  logic [7:0]       r_an;

  logic             w_div_last;
  logic             w_frame_end;
  logic             w_accept;
  logic [3:0]       w_nibble;
  logic [6:0]       w_next_sseg;
  logic             w_next_dp;
  logic [7:0]       w_next_an;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  function automatic logic lead_zero(input logic [31:0] v, input logic [2:0] d);
    logic [31:0] sh;
    sh = v >> {d, 2'b00};
    return (d != 3'd0) && (sh == 32'h0000_0000);
  endfunction
`endif

  assign w_div_last      = (r_div == DIV_LAST);
  assign w_frame_end     = w_div_last && (r_dig == 3'd7);
  assign w_accept        = value_valid_in && !r_pend;
  assign w_nibble        = r_disp_val[{r_dig, 2'b00} +: 4];
  assign value_ready_out = ~r_pend;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_div <= {DIV_W{1'b0}};
      r_dig <= 3'd0;
    end else if (w_div_last) begin
      r_div <= {DIV_W{1'b0}};
      r_dig <= r_dig + 3'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
      r_dig <= r_dig;
    end
  end

  // Accept and frame-end release are mutually exclusive: one needs pending low, the other high.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_disp_val   <= 32'h0000_0000;
      r_disp_dp    <= 8'h00;
      r_shadow_val <= 32'h0000_0000;
      r_shadow_dp  <= 8'h00;
      r_pend       <= 1'b0;
    end else if (w_accept) begin
      r_shadow_val <= value_in;
      r_shadow_dp  <= dp_mask_in;
      r_pend       <= 1'b1;
    end else if (w_frame_end && r_pend) begin
      r_disp_val <= r_shadow_val;
      r_disp_dp  <= r_shadow_dp;
      r_pend     <= 1'b0;
    end else begin
      r_pend <= r_pend;
    end
  end

  always_comb begin
    w_next_an   = 8'hFF;
    w_next_sseg = 7'h7F;
    w_next_dp   = 1'b1;
    if (r_div != {DIV_W{1'b0}}) begin
      w_next_an = ~(8'h01 << r_dig);
      w_next_dp = ~r_disp_dp[r_dig];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      if (lead_zero(r_disp_val, r_dig)) begin
        w_next_sseg = 7'h7F;
      end else begin
        w_next_sseg = hex_glyph(w_nibble);
      end
`else
      w_next_sseg = hex_glyph(w_nibble);
`endif
    end else begin
      w_next_an   = 8'hFF;
      w_next_sseg = 7'h7F;
      w_next_dp   = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_an   <= 8'hFF;
      r_sseg <= 7'h7F;
      r_dp   <= 1'b1;
    end else begin
      r_an   <= w_next_an;
      r_sseg <= w_next_sseg;
      r_dp   <= w_next_dp;
    end
  end

  assign an_out   = r_an;
  assign sseg_out = r_sseg;
  assign dp_out   = r_dp;

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (legal range 2 to 2^20).
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock (100 MHz board clock).
REQ-003 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port value_in, input, 32 bits: eight hex nibbles; nibble k drives digit k (digit 0 = rightmost).
REQ-005 SHALL have port dp_mask_in, input, 8 bits: bit k high lights the decimal point of digit k.
REQ-006 SHALL have port value_valid_in, input, 1 bit: producer offers value_in/dp_mask_in.
REQ-007 SHALL have port value_ready_out, output, 1 bit: block can accept an offer.
REQ-008 SHALL have port sseg_out, output, 7 bits, active-low segments; bit 0 = a through bit 6 = g.
REQ-009 SHALL have port dp_out, output, 1 bit, active-low decimal point.
REQ-010 SHALL have port an_out, output, 8 bits, active-low anodes; bit k enables digit k.

Function
REQ-011 SHALL accept an offer on any cycle where value_valid_in and value_ready_out are both high, capturing value_in and dp_mask_in into a shadow register and setting a pending flag.
REQ-012 SHALL drive value_ready_out as the inverse of the pending flag; an offer while pending SHALL be ignored and the producer holds it.
REQ-013 SHALL copy shadow into the display register and clear pending only at a frame boundary: the cycle digit index wraps 7 -> 0; no torn frames.
REQ-014 SHALL run a divider counting 0 to REFRESH_DIV-1; on terminal count it wraps to 0 and the digit index advances by 1, modulo 8.
REQ-015 SHALL blank all anodes (an_out = 8'hFF) for the divider-count-0 cycle of every slot (anti-ghosting), then drive the selected anode low for counts 1 to REFRESH_DIV-1.
REQ-016 SHALL encode standard hex glyphs 0-F; examples: 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110.
REQ-017 SHALL register sseg_out, dp_out and an_out so they update one cycle after the digit index/divider change, with all three aligned.
REQ-018 SHALL drive dp_out low in a slot only when the display-register dp bit for that digit is high.
REQ-019 SHALL not accept an offer arriving on the frame-boundary cycle when pending is set: ready is still low that cycle, and the offer is taken on the next cycle.

Reset
REQ-020 SHALL, while rst_in is high on a clock edge, set the divider, digit index, display register, shadow and pending to 0.
REQ-021 SHALL drive value_ready_out to 1, an_out to 8'hFF, sseg_out to 7'h7F and dp_out to 1 on the cycle after reset.
REQ-022 SHALL discard any pending offer when reset is asserted mid-frame; the display restarts at digit 0 showing 0.

Configuration
REQ-023 SHALL, with macro SSEG_LEADING_ZERO_BLANK_EN defined, blank (sseg_out = 7'h7F) every digit above the highest nonzero nibble. Digit 0 is never blanked. A lit decimal point is unaffected.
REQ-024 SHALL, without SSEG_LEADING_ZERO_BLANK_EN, show all eight digits, including leading zeros.

Verification (REFRESH_DIV=4)
REQ-025 SHALL verify reset: hold rst_in 3 cycles -> an_out=8'hFF, sseg_out=7'h7F, dp_out=1, value_ready_out=1; first anode low (an_out=8'hFE) on the 2nd cycle after release.
REQ-026 SHALL verify scan: load 32'h76543210 -> each digit slot lasts 4 cycles with 1 blank cycle; glyph sequence 0..7 on an_out FE, FD, FB, ... 7F, then repeats.
REQ-027 SHALL verify handshake: offer 32'h1 mid-frame -> ready drops the next cycle; a second offer 32'h2 is held off; new value appears only from digit 0 of the next frame; ready rises at that boundary; 32'h2 loads one cycle later.
REQ-028 SHALL verify decimal points: dp_mask_in=8'h81 -> dp_out low only in digit 0 and digit 7 slots.
REQ-029 SHALL verify blanking: value 32'h000000A0, macro defined -> digits 2-7 give sseg_out=7'h7F, digit 1 gives glyph A, digit 0 gives glyph 0; macro undefined -> digits 2-7 show glyph 0.
REQ-030 SHALL verify reset mid-operation: assert rst_in while pending with 32'hFFFFFFFF -> after release, ready=1 and digit 0 shows glyph 0.
